// File: rtl/dma_engine_pkg.sv
// dma_engine shared definitions: FSM state encoding,
// register-select codes and the default ext-port timeout.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } dma_state_e;

    localparam logic [1:0] DMA_SEL_SRC_L = 2'd0;
    localparam logic [1:0] DMA_SEL_SRC_U = 2'd1;
    localparam logic [1:0] DMA_SEL_DST   = 2'd2;
    localparam logic [1:0] DMA_SEL_AMT   = 2'd3;

    localparam int DMA_EXT_TIMEOUT = 64;

endpackage

// File: rtl/dma_engine_if.sv
// dma_engine bus bundle: CPU register window, status, system bus
// write port and external read port. master = engine, slave = system.
interface dma_engine_if #(
    parameter int ADDR_W     = 16,
    parameter int EXT_ADDR_W = 32,
    parameter int DATA_W     = 16
);
    logic                  dma_en;
    logic [1:0]            dma_mode;
    logic                  memwrite;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     dma_regdata;
    logic                  busy;
    logic                  error;
    logic                  cpu_stall;
    logic [ADDR_W-1:0]     dma_memaddr;
    logic                  dma_memwrite;
    logic [DATA_W-1:0]     dma_writedata;
    logic [EXT_ADDR_W-1:0] ext_addr;
    logic                  ext_req;
    logic                  ext_ack;
    logic [DATA_W-1:0]     ext_data;

    modport master (
        input  dma_en, dma_mode, memwrite, writedata,
        input  ext_ack, ext_data,
        output dma_regdata, busy, error, cpu_stall,
        output dma_memaddr, dma_memwrite, dma_writedata,
        output ext_addr, ext_req
    );

    modport slave (
        output dma_en, dma_mode, memwrite, writedata,
        output ext_ack, ext_data,
        input  dma_regdata, busy, error, cpu_stall,
        input  dma_memaddr, dma_memwrite, dma_writedata,
        input  ext_addr, ext_req
    );
endinterface

// File: rtl/dma_engine_regs.sv
// dma_regs: DMA register file (src, dst, count), write decode,
// registered readback and per-word pointer advance.
// Ports: clk/rst, idle, sel_en/we/sel/wdata (CPU window), step
// (a WRITE completes), fill (hold src), rdata, start, last, src, dst.
module dma_regs
    import dma_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int EXT_ADDR_W = 32,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idle,
    input  logic                  sel_en,
    input  logic                  we,
    input  logic [1:0]            sel,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  step,
    input  logic                  fill,
    output logic [DATA_W-1:0]     rdata,
    output logic                  start,
    output logic                  last,
    output logic [EXT_ADDR_W-1:0] src,
    output logic [ADDR_W-1:0]     dst
);
    localparam int HI_W = EXT_ADDR_W - DATA_W;

    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] rsel;
    logic              wr;

    assign wr    = idle && sel_en && we;
    assign start = wr && (sel == DMA_SEL_AMT) && (wdata != '0);
    assign last  = (cnt == ADDR_W'(1));

    always_comb begin
        rsel = '0;
        unique case (sel)
            DMA_SEL_SRC_L: rsel = src[DATA_W-1:0];
            DMA_SEL_SRC_U: rsel = DATA_W'(src >> DATA_W);
            DMA_SEL_DST:   rsel = DATA_W'(dst);
            DMA_SEL_AMT:   rsel = DATA_W'(cnt);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            if (sel_en)
                rdata <= rsel;
            if (wr) begin
                unique case (sel)
                    DMA_SEL_SRC_L: src[DATA_W-1:0] <= wdata;
                    DMA_SEL_SRC_U: src[EXT_ADDR_W-1:DATA_W] <= HI_W'(wdata);
                    DMA_SEL_DST:   dst <= ADDR_W'(wdata);
                    DMA_SEL_AMT:   if (wdata != '0) cnt <= ADDR_W'(wdata);
                endcase
            end
            // Advance on each completed word; fill keeps src as the pattern.
            if (step) begin
                if (!fill)
                    src <= src + EXT_ADDR_W'(1);
                dst <= dst + ADDR_W'(1);
                cnt <= cnt - ADDR_W'(1);
            end
        end
    end
endmodule

// File: rtl/dma_engine.sv
// dma_engine: block copy from external word memory into CPU space.
// Ports: clk, rst, bus (dma_engine_if.master). Option: DMA_FILL_EN.
module dma_engine
    import dma_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int EXT_ADDR_W  = 32,
    parameter int DATA_W      = 16,
    parameter int EXT_TIMEOUT = DMA_EXT_TIMEOUT
) (
    input logic           clk,
    input logic           rst,
    dma_engine_if.master  bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_READ  = READ;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam int TW = $clog2(EXT_TIMEOUT + 1);

    logic [1:0]            state;
    logic [TW-1:0]         tcnt;
    logic                  err;
    logic                  fill_q;
    logic                  fill_req;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     rdata;
    logic                  start;
    logic                  last;
    logic [EXT_ADDR_W-1:0] src;
    logic [ADDR_W-1:0]     dst;
    logic                  busy;

    dma_regs #(
        .ADDR_W     (ADDR_W),
        .EXT_ADDR_W (EXT_ADDR_W),
        .DATA_W     (DATA_W)
    ) u_regs (
        .clk    (clk),
        .rst    (rst),
        .idle   (state == S_IDLE),
        .sel_en (bus.dma_en),
        .we     (bus.memwrite),
        .sel    (bus.dma_mode),
        .wdata  (bus.writedata),
        .step   (state == S_WRITE),
        .fill   (fill_q),
        .rdata  (rdata),
        .start  (start),
        .last   (last),
        .src    (src),
        .dst    (dst)
    );

`ifdef DMA_FILL_EN
    assign fill_req = src[EXT_ADDR_W-1];
`else
    assign fill_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            tcnt   <= '0;
            err    <= 1'b0;
            fill_q <= 1'b0;
            data_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err    <= 1'b0;
                        tcnt   <= '0;
                        fill_q <= fill_req;
                        state  <= fill_req ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    if (bus.ext_ack) begin
                        data_q <= bus.ext_data;
                        tcnt   <= '0;
                        state  <= S_WRITE;
                    end else if (tcnt == TW'(EXT_TIMEOUT - 1)) begin
                        // Abort; pointers stay on the failing word.
                        err   <= 1'b1;
                        tcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    if (last)
                        state <= S_IDLE;
                    else
                        state <= fill_q ? S_WRITE : S_READ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy              = (state != S_IDLE);
    assign bus.busy          = busy;
    assign bus.cpu_stall     = busy;
    assign bus.error         = err;
    assign bus.dma_regdata   = rdata;
    assign bus.ext_req       = (state == S_READ);
    assign bus.ext_addr      = src;
    assign bus.dma_memwrite  = (state == S_WRITE);
    assign bus.dma_memaddr   = dst;
    assign bus.dma_writedata = fill_q ? src[DATA_W-1:0] : data_q;
endmodule
